// File: rtl/gcd_shared_scheduler.sv
// gcd_shared_scheduler: round-robin controller sharing one subtractive GCD datapath; GCD_ITER_LIMIT_EN adds a step-limit abort
module gcd_shared_scheduler #(
    parameter int N = 16,
    parameter int NREQ = 4,
    parameter int MAX_ITER = 1000,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [N-1:0]      dp_dataA,
    output logic [N-1:0]      dp_dataB,
    output logic              dp_loadA,
    output logic              dp_loadB,
    output logic              dp_selLoadA,
    output logic              dp_selLoadB,
    input  logic              dp_lt,
    input  logic              dp_gt,
    input  logic              dp_eq,
    input  logic [N-1:0]      dp_result
);
    if (NREQ < 2 || NREQ > 8 || MAX_ITER < 1) begin : g_bad_cfg
        $error("gcd_shared_scheduler: NREQ must be 2..8 and MAX_ITER positive");
    end

    typedef enum logic [2:0] {IDLE, LOAD, CMP, SUBA, SUBB, RESP} state_t;
    state_t state;
    logic [IDW-1:0] rr_ptr;
    logic [N-1:0] op_a, op_b;
    logic [IDW-1:0] gid;
    logic found;
    logic [N-1:0] sel_a, sel_b;

    function automatic logic [IDW-1:0] wrap(input int v);
        return IDW'(v >= NREQ ? v - NREQ : v);
    endfunction

    // scan from the farthest offset down so the nearest valid requester at or after rr_ptr wins
    always_comb begin
        gid = '0;
        found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[wrap(int'(rr_ptr) + i)]) begin
                gid = wrap(int'(rr_ptr) + i);
                found = 1'b1;
            end
        end
    end

    assign sel_a = req_a[gid*N +: N];
    assign sel_b = req_b[gid*N +: N];
    assign req_ready = (reset_n && state == IDLE && found) ? NREQ'(1) << gid : '0;
    assign rsp_valid = state == RESP;
    assign busy = state != IDLE;
    assign dp_dataA = op_a;
    assign dp_dataB = op_b;
    assign dp_loadA = state == LOAD || state == SUBA;
    assign dp_loadB = state == LOAD || state == SUBB;
    assign dp_selLoadA = state == SUBA;
    assign dp_selLoadB = state == SUBB;

`ifdef GCD_ITER_LIMIT_EN
    logic [N-1:0] iter;
    logic err_q;
    assign rsp_err = state == RESP && err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            op_a <= '0;
            op_b <= '0;
            rsp_data <= '0;
            rsp_id <= '0;
`ifdef GCD_ITER_LIMIT_EN
            iter <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (found) begin
                    op_a <= sel_a;
                    op_b <= sel_b;
                    rsp_id <= gid;
                    rr_ptr <= wrap(int'(gid) + 1);
`ifdef GCD_ITER_LIMIT_EN
                    iter <= '0;
                    err_q <= 1'b0;
`endif
                    if (sel_a == '0 || sel_b == '0) begin
                        rsp_data <= sel_a | sel_b;
                        state <= RESP;
                    end else begin
                        state <= LOAD;
                    end
                end
                LOAD: state <= CMP;
                CMP: if (dp_eq) begin
                    rsp_data <= dp_result;
                    state <= RESP;
                end
`ifdef GCD_ITER_LIMIT_EN
                else if (iter == N'(MAX_ITER)) begin
                    rsp_data <= '0;
                    err_q <= 1'b1;
                    state <= RESP;
                end
`endif
                else if (dp_gt) state <= SUBA;
                else if (dp_lt) state <= SUBB;
                SUBA, SUBB: begin
                    state <= CMP;
`ifdef GCD_ITER_LIMIT_EN
                    iter <= iter + 1'b1;
`endif
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_shared_scheduler.sv
// tb_gcd_shared_scheduler: directed vectors against a behavioural subtractive GCD datapath
module tb_gcd_shared_scheduler;
    localparam int N = 16;
    localparam int NREQ = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [NREQ-1:0] req_valid, req_ready;
    logic [NREQ*N-1:0] req_a, req_b;
    logic rsp_valid, rsp_err, busy;
    logic [1:0] rsp_id;
    logic [N-1:0] rsp_data, dp_dataA, dp_dataB, dp_result;
    logic dp_loadA, dp_loadB, dp_selLoadA, dp_selLoadB, dp_lt, dp_gt, dp_eq;
    logic [N-1:0] da = '0, db = '0;
    int passed = 0, total = 0;

    always #5 clock = ~clock;

    gcd_shared_scheduler #(.N(N), .NREQ(NREQ), .MAX_ITER(4)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .dp_dataA(dp_dataA),
        .dp_dataB(dp_dataB), .dp_loadA(dp_loadA), .dp_loadB(dp_loadB),
        .dp_selLoadA(dp_selLoadA), .dp_selLoadB(dp_selLoadB), .dp_lt(dp_lt),
        .dp_gt(dp_gt), .dp_eq(dp_eq), .dp_result(dp_result)
    );

    always @(posedge clock) begin
        if (dp_loadA) da <= dp_selLoadA ? da - db : dp_dataA;
        if (dp_loadB) db <= dp_selLoadB ? db - da : dp_dataB;
    end
    assign dp_lt = da < db;
    assign dp_gt = da > db;
    assign dp_eq = da == db;
    assign dp_result = da;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic run_job(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] exp_d, input int exp_lat, input logic exp_err);
        bit got = 0;
        bit strobe = 0;
        int lat = 0;
        int busy_cnt = 0;
        @(posedge clock); #1;
        req_a[id*N +: N] = a;
        req_b[id*N +: N] = b;
        req_valid[id] = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clock);
            got = req_ready[id];
        end
        check("accept", 32'(got), 1);
        check("ready_onehot", 32'(req_ready), 32'(1) << id);
        check("idle_not_busy", 32'(busy), 0);
        @(posedge clock); #1;
        req_valid[id] = 1'b0;
        got = 0;
        while (!got && lat < 100) begin
            @(negedge clock);
            lat++;
            busy_cnt += int'(busy);
            strobe |= dp_loadA | dp_loadB;
            got = rsp_valid;
        end
        check("latency", lat, exp_lat);
        check("rsp_data", 32'(rsp_data), 32'(exp_d));
        check("rsp_id", 32'(rsp_id), id);
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("busy_cycles", busy_cnt, exp_lat);
        if (exp_lat == 1) check("no_dp_strobe", 32'(strobe), 0);
    endtask

    typedef struct {
        int id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] d;
        int lat;
    } vec_t;
    vec_t vecs[6];
    logic [N-1:0] a3[4], b3[4], d3[4];

    initial begin
        bit got;
        bit seen;
        logic [NREQ-1:0] gm;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        vecs[0] = '{0, 16'd26, 16'd13, 16'd13, 5};
        vecs[1] = '{1, 16'd0, 16'd7, 16'd7, 1};
        vecs[2] = '{1, 16'd0, 16'd0, 16'd0, 1};
        vecs[3] = '{2, 16'd35, 16'd64, 16'd1, 25};
        vecs[4] = '{3, 16'd7, 16'd0, 16'd7, 1};
        vecs[5] = '{0, 16'd5, 16'd5, 16'd5, 3};
        a3 = '{16'd12, 16'd9, 16'd0, 16'd14};
        b3 = '{16'd8, 16'd3, 16'd5, 16'd21};
        d3 = '{16'd4, 16'd3, 16'd5, 16'd7};

        repeat (2) @(negedge clock);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_strobes", 32'({dp_loadA, dp_loadB, dp_selLoadA, dp_selLoadB}), 0);
        check("rst_data", 32'({dp_dataA, dp_dataB}), 0);
        check("rst_rsp", 32'({rsp_data, rsp_id, rsp_err}), 0);
        reset_n = 1'b1;

        for (int v = 0; v < 6; v++)
            run_job(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].d, vecs[v].lat, 1'b0);

        // all four contend straight after reset, so grants must go 0,1,2,3
        @(negedge clock) reset_n = 1'b0;
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = a3[i];
            req_b[i*N +: N] = b3[i];
        end
        req_valid = '1;
        for (int g = 0; g < NREQ; g++) begin
            got = 0;
            for (int t = 0; t < 50 && !got; t++) begin
                @(negedge clock);
                got = |req_ready;
            end
            gm = req_ready;
            check("rr_grant", 32'(gm), 32'(1) << g);
            @(posedge clock); #1;
            req_valid &= ~gm;
            got = 0;
            for (int t = 0; t < 100 && !got; t++) begin
                @(negedge clock);
                got = rsp_valid;
            end
            check("rr_rsp_seen", 32'(got), 1);
            check("rr_rsp_id", 32'(rsp_id), g);
            check("rr_rsp_data", 32'(rsp_data), 32'(d3[g]));
        end
        req_valid = '0;
        @(posedge clock); #1;
        req_a[2*N +: N] = 16'd0;
        req_b[2*N +: N] = 16'd9;
        req_valid = 4'b0100;
        @(negedge clock);
        check("wrap_grant", 32'(req_ready), 32'h4);
        @(posedge clock); #1;
        req_valid = '0;
        @(negedge clock);
        check("wrap_rsp", 32'({rsp_valid, rsp_id, rsp_data}), {15'd0, 1'b1, 2'd2, 16'd9});

        // async reset in the middle of a subtraction must drop the job silently
        @(posedge clock); #1;
        req_a[0 +: N] = 16'd26;
        req_b[0 +: N] = 16'd13;
        req_valid[0] = 1'b1;
        got = 0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clock);
            got = req_ready[0];
        end
        @(posedge clock); #1;
        req_valid = '0;
        got = 0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clock);
            got = dp_selLoadA;
        end
        check("reached_suba", 32'(got), 1);
        reset_n = 1'b0;
        #1;
        check("async_busy", 32'(busy), 0);
        check("async_strobes", 32'({dp_loadA, dp_loadB, dp_selLoadA, dp_selLoadB}), 0);
        check("async_data", 32'({dp_dataA, dp_dataB}), 0);
        check("async_rsp", 32'({rsp_valid, rsp_data, rsp_id, rsp_err}), 0);
        seen = 0;
        repeat (2) begin
            @(negedge clock);
            seen |= rsp_valid;
        end
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clock);
            seen |= rsp_valid;
        end
        check("no_rsp_after_reset", 32'(seen), 0);
        run_job(3, 16'd48, 16'd18, 16'd6, 11, 1'b0);

`ifdef GCD_ITER_LIMIT_EN
        run_job(0, 16'd1, 16'd200, 16'd0, 11, 1'b1);
        run_job(1, 16'd26, 16'd13, 16'd13, 5, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gcd_shared_scheduler.md
Name: gcd_shared_scheduler

Overview:
Controller and round-robin arbiter that shares one repeated-subtraction GCD datapath between NREQ requesters. It accepts one operand pair at a time and steers it onto the datapath data inputs. It then drives the datapath load/select strobes from the datapath's lt/gt/eq flags and returns the result tagged with the requester ID. It replaces the single-user start/done controller wherever several masters need GCD service.

Parameters:
N, 16, operand/result width; matches the datapath width.
NREQ, 4, number of requesters (2..8). IDW = $clog2(NREQ), derived.
MAX_ITER, 1000, subtraction-step limit; used only with GCD_ITER_LIMIT_EN.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request; held with its operands until accepted
req_ready  output  NREQ  one-hot acceptance strobe, one cycle
req_a  input  NREQ*N  flat operand A; requester i uses [i*N +: N]
req_b  input  NREQ*N  flat operand B; same packing
rsp_valid  output  1  one-cycle result pulse; no backpressure
rsp_id  output  IDW  requester index of the result
rsp_data  output  N  GCD result
rsp_err  output  1  iteration-limit abort flag; tied 0 when the feature is out
busy  output  1  high in every state except IDLE
dp_dataA  output  N  to datapath dataInA
dp_dataB  output  N  to datapath dataInB
dp_loadA, dp_loadB, dp_selLoadA, dp_selLoadB  output  1 each  datapath strobes
dp_lt, dp_gt, dp_eq  input  1 each  datapath comparator flags
dp_result  input  N  datapath register A output

Behaviour:
- Reset: state=IDLE, rr_ptr=0, captured operands=0, rsp_data=0, rsp_id=0, iteration count=0. All outputs 0. Reset mid-operation discards the in-flight request; no response is produced for it.
- States: IDLE, LOAD, CMP, SUBA, SUBB, RESP. Strobes decode from the state register only:
  - LOAD: loadA=1, loadB=1, sel=0.
  - SUBA: loadA=1, selLoadA=1.
  - SUBB: loadB=1, selLoadB=1.
  - All strobes are 0 in every other state.
- dp_dataA/dp_dataB always drive the captured operand registers.
- IDLE: the grant is the first asserted req_valid searching upward from rr_ptr, wrapping at NREQ.
  - The granted requester sees req_ready high in the same cycle. Its operands and ID are captured at that edge. rr_ptr becomes (grant+1) mod NREQ.
  - If either captured operand is 0: rsp_data <= a|b (0,0 gives 0), next state RESP, datapath untouched.
  - Otherwise next state is LOAD.
  - No valid requests: remain in IDLE, req_ready=0.
- LOAD -> CMP.
- CMP: eq -> RESP, capturing dp_result into rsp_data. gt -> SUBA. lt -> SUBB. Priority order is eq, gt, lt.
- SUBA/SUBB -> CMP; the iteration count increments.
- RESP: rsp_valid=1, rsp_err per feature. Next state is IDLE, with no new grant in the RESP cycle.
- Latency, with accept at T0 and k subtraction steps: rsp_valid at T0+3+2k. Zero-operand path: rsp_valid at T0+1.
- req_ready is never asserted outside IDLE. A requester dropping valid before acceptance is simply not served.

Optional Feature:
GCD_ITER_LIMIT_EN:
- Defined: an N-bit step counter is cleared on accept. If a SUBA/SUBB step would make the count equal MAX_ITER while still not eq, the next state is RESP with rsp_err=1 and rsp_data=0.
- Undefined: no counter, rsp_err constant 0, and iteration is unbounded.

Test Plan:
1. Requester 0 only, A=26, B=13, accepted at T0. Required: states LOAD, CMP, SUBA, CMP, RESP; rsp_valid at T0+5 with rsp_data=13, rsp_id=0, rsp_err=0.
2. Requester 1, A=0, B=7. Required: rsp_valid at T0+1, rsp_data=7, rsp_id=1, no dp_load strobe ever high. Repeat with A=0, B=0: rsp_data=0.
3. All four requesters valid after reset with distinct pairs. Required: req_ready order 0,1,2,3, one response per grant with matching IDs. Then only requester 2 valid: granted immediately, since rr_ptr has wrapped to 0 and the search reaches 2.
4. A=35, B=64. Required: rsp_data=1 at T0+25 (11 steps), busy high from T0+1 through T0+25.
5. reset_n pulled low during SUBA of a 26/13 job. Required: all outputs 0 asynchronously and no rsp_valid for that job. After release, a new 48/18 request returns 6.
6. With GCD_ITER_LIMIT_EN and MAX_ITER=4, A=1, B=200. Required: rsp_valid with rsp_err=1, rsp_data=0 at T0+3+2*4.
